// File: rtl/pwl_pkg.sv
// Shared constants and types for the PWL sigmoid stream: Q8.8 format, segment
// count, default coefficient table and the segment/coefficient types.
package pwl_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int NSEG = 6;
  localparam int AW   = 3;

  localparam logic [DW-1:0] ONE = 16'h0100;

  typedef logic [AW-1:0] seg_t;

  typedef struct packed {
    logic [DW-1:0] grad;
    logic [DW-1:0] off;
  } coef_t;

  // Entry 0 is the rightmost element of each concatenation.
  localparam logic [NSEG-1:0][DW-1:0] DEF_GRAD =
    {16'h0001, 16'h0003, 16'h0008, 16'h0012, 16'h0026, 16'h003B};
  localparam logic [NSEG-1:0][DW-1:0] DEF_OFF =
    {16'h00F9, 16'h00F0, 16'h00DD, 16'h00BD, 16'h0090, 16'h0080};

  function automatic coef_t def_coef(input int k);
    coef_t c;
    c.grad = DEF_GRAD[k];
    c.off  = DEF_OFF[k];
    return c;
  endfunction

endpackage

// File: rtl/pwl_coef_table.sv
// Per-segment gradient/offset register file: async reset to the default curve,
// one write port (out-of-range addresses dropped), one combinational read port.
module pwl_coef_table
  import pwl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we_i,
  input  seg_t  waddr_i,
  input  coef_t wdata_i,
  input  seg_t  raddr_i,
  output coef_t rdata_o
);

  coef_t tbl_q [NSEG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) tbl_q[k] <= def_coef(k);
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (we_i && (waddr_i == seg_t'(k))) tbl_q[k] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (raddr_i == seg_t'(k)) rdata_o = tbl_q[k];
    end
  end

endmodule

// File: rtl/pwl_sigmoid_stream.sv
// Two-stage streaming PWL sigmoid evaluator, Q8.8, valid/ready on both sides.
// Build macro PWL_ROUND_EN: round-half-up the gradient product instead of truncating.
module pwl_sigmoid_stream
  import pwl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_grad,
  input  logic [DW-1:0] cfg_off
);

  localparam logic [DW-FRAC-2:0] SEG_MAX_INT = (DW-FRAC-1)'(NSEG-1);

  logic          s1_v_q,    s1_v_d;
  logic          s1_sign_q, s1_sign_d;
  logic [DW-1:0] s1_mag_q,  s1_mag_d;
  coef_t         s1_coef_q, s1_coef_d;
  logic          out_v_q,   out_v_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          s2_en, s1_en;
  logic [DW-1:0] mag;
  logic [DW-FRAC-2:0] int_part;
  seg_t          seg;
  coef_t         coef_rd;
  coef_t         cfg_wdata;

  logic [2*DW-1:0] prod, prod_r;
  logic [DW-1:0]   q;
  logic [DW:0]     sum;
  logic [DW-1:0]   sat, res;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_en    = !out_v_q || out_ready;
  assign s1_en    = !s1_v_q || s2_en;
  assign in_ready = s1_en;

  always_comb begin
    mag = in_data[DW-1] ? (~in_data + 16'd1) : in_data;
    if (in_data == 16'h8000) mag = 16'h7FFF;
    int_part = mag[DW-2:FRAC];
    seg      = (int_part >= SEG_MAX_INT) ? seg_t'(NSEG-1) : int_part[AW-1:0];
  end

  assign cfg_wdata.grad = cfg_grad;
  assign cfg_wdata.off  = cfg_off;

  pwl_coef_table u_coef_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (seg),
    .rdata_o (coef_rd)
  );

  always_comb begin
    prod = {16'b0, s1_coef_q.grad} * {16'b0, s1_mag_q};
`ifdef PWL_ROUND_EN
    prod_r = prod + 32'h0000_0080;
`else
    prod_r = prod;
`endif
    q   = prod_r[DW+FRAC-1:FRAC];
    sum = {1'b0, q} + {1'b0, s1_coef_q.off};
    sat = (sum > {1'b0, ONE}) ? ONE : sum[DW-1:0];
    res = s1_sign_q ? (ONE - sat) : sat;
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_coef_d  = s1_coef_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    if (s2_en) begin
      out_v_d = s1_v_q;
      if (s1_v_q) out_data_d = res;
    end
    if (s1_en) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_data[DW-1];
        s1_mag_d  = mag;
        s1_coef_d = coef_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_coef_q  <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_coef_q  <= s1_coef_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pwl_sigmoid_stream.sv
// Bench for pwl_sigmoid_stream: directed and random samples scored against an
// arithmetic model of the PWL curve with an in-order expected-result queue.
module tb_pwl_sigmoid_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cfg_we;
  logic [15:0] in_data, out_data, cfg_grad, cfg_off;
  logic [2:0]  cfg_addr;

  pwl_sigmoid_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_grad  (cfg_grad),
    .cfg_off   (cfg_off)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  int          tgrad [6];
  int          toff  [6];
  logic [15:0] exp_q [$];
  longint      acc_q [$];
  bit          lat_chk = 1'b1;
  bit          force_en = 1'b0;
  logic [15:0] force_val = '0;
  bit          last_in_fire = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic load_defaults();
    tgrad = '{59, 38, 18, 8, 3, 1};
    toff  = '{128, 144, 189, 221, 240, 249};
  endtask

  // Curve evaluated from the table with plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] x);
    int     a, seg;
    longint p, qv, s;
    bit     neg;
    neg = x[15];
    if (x == 16'h8000)  a = 32767;
    else if (neg)       a = 65536 - int'(x);
    else                a = int'(x);
    seg = a / 256;
    if (seg > 5) seg = 5;
    p = longint'(tgrad[seg]) * longint'(a);
`ifdef PWL_ROUND_EN
    p = p + 128;
`endif
    qv = (p / 256) % 65536;
    s  = qv + longint'(toff[seg]);
    if (s > 256) s = 256;
    if (neg) s = 256 - s;
    return 16'(s);
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes at the falling edge, return #1 after the rising edge.
  task automatic tick();
    bit          in_fire, out_fire;
    logic [15:0] e;
    longint      t;
    @(negedge clk);
    last_in_fire = 1'b0;
    if (rst_n) begin
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      check1("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      if (prev_stall) begin
        check1("stall_valid", out_valid, 1'b1);
        check16("stall_data", out_data, prev_data);
      end
      if (exp_q.size() == 0) check1("spurious_out", out_valid, 1'b0);
      if (lat_chk && exp_q.size() > 0 && (cyc - acc_q[0]) >= 2)
        check1("latency_valid", out_valid, 1'b1);
      if (out_fire && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check16("out_data", out_data, e);
        if (lat_chk) check16("latency", 16'(cyc - t), 16'd2);
      end
      if (in_fire) begin
        exp_q.push_back(force_en ? force_val : model(in_data));
        acc_q.push_back(cyc);
        last_in_fire = 1'b1;
      end
      if (cfg_we && cfg_addr < 3'd6) begin
        tgrad[cfg_addr] = int'(cfg_grad);
        toff[cfg_addr]  = int'(cfg_off);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] x, input bit fe, input logic [15:0] fv);
    int g;
    force_en  = fe;
    force_val = fv;
    in_valid  = 1'b1;
    in_data   = x;
    g = 0;
    do begin
      tick();
      g++;
    end while (!last_in_fire && g < 50);
    in_valid = 1'b0;
    force_en = 1'b0;
    n_vec++;
    assert (last_in_fire) else begin
      n_err++;
      $error("FAIL send_timeout: operand %h not accepted, expected acceptance within 50 cycles", x);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 50) begin
      tick();
      g++;
    end
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  logic [15:0] xs [8];
  logic [23:0] bp_pat;
  int          idx, g;

  initial begin
    load_defaults();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_grad = '0; cfg_off = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_out_data", out_data, 16'h0000);
    check1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed curve points, no backpressure.
    send(16'h0000, 1'b1, 16'h0080); drain();
    send(16'h0100, 1'b1, 16'h00B6); drain();
    send(16'h0500, 1'b1, 16'h00FE); drain();
`ifdef PWL_ROUND_EN
    send(16'h0080, 1'b1, 16'h009E); drain();
`else
    send(16'h0080, 1'b1, 16'h009D); drain();
`endif
    send(16'hFF00, 1'b1, 16'h004A); drain();
    send(16'h0A00, 1'b1, 16'h0100); drain();
    send(16'hF600, 1'b1, 16'h0000); drain();
    send(16'h8000, 1'b1, 16'h0000); drain();
    send(16'h7FFF, 1'b1, 16'h0100); drain();
    send(16'h0280, 1'b0, 16'h0000);
    send(16'hFD40, 1'b0, 16'h0000);
    send(16'h03FF, 1'b0, 16'h0000);
    send(16'hFC01, 1'b0, 16'h0000);
    drain();

    // Write lands in the same cycle as acceptance: old coefficient, then new.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_grad = 16'h0040; cfg_off = 16'h0000;
`ifdef PWL_ROUND_EN
    send(16'h0080, 1'b1, 16'h009E);
`else
    send(16'h0080, 1'b1, 16'h009D);
`endif
    cfg_we = 1'b0;
    send(16'h0080, 1'b1, 16'h0020);
    drain();
    cfg_we = 1'b1; cfg_addr = 3'd7; cfg_grad = 16'hFFFF; cfg_off = 16'hFFFF;
    tick();
    cfg_addr = 3'd6;
    tick();
    cfg_we = 1'b0;
    send(16'h0080, 1'b1, 16'h0020);
    send(16'h0500, 1'b1, 16'h00FE);
    send(16'h0300, 1'b0, 16'h0000);
    drain();

    // Back-to-back stream under a fixed then random backpressure pattern.
    lat_chk = 1'b0;
    xs = '{16'h0040, 16'hFFC0, 16'h0180, 16'hFE20, 16'h0333, 16'h04F0, 16'hFA00, 16'h0123};
    bp_pat = 24'b1011_0110_1100_0001_0000_0110;
    idx = 0;
    in_valid = 1'b1;
    in_data  = xs[0];
    g = 0;
    while ((idx < 8 || exp_q.size() > 0) && g < 200) begin
      out_ready = (g < 24) ? bp_pat[g] : 1'($urandom);
      tick();
      if (last_in_fire) begin
        idx++;
        if (idx < 8) in_data = xs[idx];
        else in_valid = 1'b0;
      end
      g++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check16("bp_all_accepted", 16'(idx), 16'd8);
    drain();

    // Random traffic with interleaved coefficient writes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      cfg_we    = ($urandom % 10) == 0;
      cfg_addr  = 3'($urandom);
      cfg_grad  = 16'($urandom % 1024);
      cfg_off   = 16'($urandom % 512);
      tick();
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two samples in flight.
    out_ready = 1'b0;
    send(16'h0100, 1'b0, 16'h0000);
    send(16'h0200, 1'b0, 16'h0000);
    tick();
    check1("inflight_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_valid", out_valid, 1'b0);
    check16("async_rst_data", out_data, 16'h0000);
    exp_q.delete();
    acc_q.delete();
    prev_stall = 1'b0;
    load_defaults();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(16'h0000, 1'b1, 16'h0080);
    send(16'h0080, 1'b0, 16'h0000);
    send(16'h0100, 1'b1, 16'h00B6);
    send(16'hFE80, 1'b0, 16'h0000);
    send(16'h0480, 1'b0, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwl_sigmoid_stream.md
Name: pwl_sigmoid_stream

Overview:
- Streaming, pipelined piecewise-linear (PWL) evaluator for the softplus_squared / sigmoid-style activation in the VAE datapath, Q8.8 signed fixed point.
- Reads per-segment gradient/offset coefficients from an internal, runtime-writable table.
- Consumer-side counterpart to the coefficient generator: a config master writes coefficients; this block reads them on every sample.
- Valid/ready on input and output; sits between the encoder MAC array and the latent-sampling stage.

Parameters:
- DW, 16, data width (Q8.8 signed)
- FRAC, 8, fractional bits
- NSEG, 6, number of segments; segment k covers |x| in [k, k+1); the last segment is open-ended
- AW, 3, coefficient table address width (2^AW >= NSEG)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand
- in_data  in  DW  operand x, Q8.8 signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  result alfa, Q8.8
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  AW  segment index to write
- cfg_grad  in  DW  gradient, Q8.8 unsigned
- cfg_off  in  DW  offset, Q8.8 unsigned

Behaviour:
- Reset values: out_valid=0, out_data=0, both pipeline-stage valids 0. The table loads these defaults (grad, offset) for segments 0..5: (003B,0080), (0026,0090), (0012,00BD), (0008,00DD), (0003,00F0), (0001,00F9).
- Reset is asynchronous: asserting rst_n low mid-operation drops all in-flight samples and restores the table defaults.
- Pipeline S1: capture sign=x[15]; a=|x|, with 0x8000 saturating to 0x7FFF; seg=min(a>>FRAC, NSEG-1); register grad/off read from the table.
- Pipeline S2: p=grad*a (32b Q16.16); q=p[23:8] truncated; s=q+off, saturated to [0x0000, 0x0100]; out = sign ? 0x0100-s : s.
- Latency: 2 cycles from the in handshake to out_valid, with no stalls. Throughput is 1 sample per cycle.
- Handshake: in_ready = !S1_valid | !S2_valid | out_ready (the pipeline advances when there is space).
- Handshake: out_data/out_valid hold stable while out_valid & !out_ready.
- Handshake: no sample is lost or duplicated under any backpressure pattern.
- cfg writes apply at the clock edge. A sample accepted in the same cycle as a write uses the old coefficient; a sample accepted the following cycle uses the new one.
- cfg_addr >= NSEG: the write is ignored.
- Simultaneous in-handshake and cfg write to the same segment: the old value is used (read-before-write).
- The table is never read in S2; coefficients travel with the sample.

Optional Feature:
- Macro: PWL_ROUND_EN
- Defined: q = (p + 0x80)[23:8], i.e. round-half-up before the offset add.
- Undefined: truncation as above.
- Saturation and symmetry are unchanged either way.

Decomposition:
- Shared package pwl_pkg holds: DW, FRAC, the ONE=16'h0100 constant, NSEG, the default gradient/offset arrays, and the seg_t/coef_t typedefs.
- One sub-module: pwl_coef_table (register file, async reset to defaults, 1 write port, 1 combinational read port).
- Datapath and handshake stay in the top.

Test Plan:
- Reset, then x=0x0000, 0x0100, 0x0500 with out_ready=1 → outputs 0x0080, 0x00B6, 0x00FE, each 2 cycles after acceptance.
- x=0x0080 → 0x009D with PWL_ROUND_EN undefined; 0x009E with it defined.
- Negative and saturation: x=0xFF00 → 0x004A; x=0x0A00 → 0x0100 (clamped); x=0xF600 → 0x0000; x=0x8000 → 0x0000, with no overflow.
- Backpressure: stream 8 operands back-to-back while out_ready toggles pseudo-randomly (including 5 consecutive low cycles) → in_ready drops only when both stages are full; all 8 results arrive in order, unchanged; out_data is stable during each stall.
- Coefficient update: write seg0=(0x0040,0x0000) in the same cycle that x=0x0080 is accepted, then send x=0x0080 again → results 0x009D (old), then 0x0020 (new); write with cfg_addr=7 → no effect.
- Mid-stream reset: pulse rst_n low while 2 samples are in flight → out_valid falls immediately (asynchronously); after release, x=0x0000 → 0x0080 (defaults restored).
